led_driver: RTL and testbench
=============================

Name: led_driver

Overview:
- Write/read interface between the SoC 4-way handshaking data bus and 8 physical LEDs.
- It is the output-side counterpart of the debounced switch reader.
- It holds an 8-bit LED pattern register and a control register (per-LED blink mask, global brightness).
- It drives the pins through a registered output stage with blink and PWM timing.

Parameters:
- BLINK_DIV, 25000000: clock cycles per blink half-period (at least 2).
- PWM_DIV, 64: clock cycles per PWM step; one PWM frame is 16 steps (at least 1).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- Read  in  1  bus read request.
- Write  in  1  bus write request.
- Address  in  1  0 = LED pattern register, 1 = control register.
- DataIn  in  16  write data.
- Ready  out  1  handshake acknowledge.
- DataOut  out  16  read data, valid while Ready=1.
- LED_out  out  8  drive to physical LEDs, active-high, registered.

Behaviour:
- Reset values (asynchronous, on reset=0):
  - Ready=0, DataOut=0, LED_out=0.
  - pattern=8'h00, blink_mask=8'h00, brightness=4'hF.
  - Blink phase = ON (0); all prescalers and counters = 0.
- Handshake FSM, two states:
  - IDLE: Ready=0. If Read|Write is sampled high, go to ACK next edge and set Ready=1.
  - ACK: Ready=1. Stay while Read|Write is high. When both are low, go to IDLE and drop Ready on the next edge.
  - Latency: request to Ready is 1 cycle; request drop to Ready drop is 1 cycle.
- Write capture:
  - Happens only on the IDLE->ACK edge; holding Write in ACK does not re-write.
  - Address 0: pattern <= DataIn[7:0].
  - Address 1: brightness <= DataIn[3:0], blink_mask <= DataIn[11:4].
  - Unused DataIn bits are ignored.
- Read capture:
  - DataOut is loaded on the IDLE->ACK edge and held until the next IDLE->ACK.
  - Address 0: {8'h00, pattern}.
  - Address 1: {4'h0, blink_mask, brightness}.
  - The captured value is the register contents before any write in the same transaction.
- Simultaneous Read and Write: the write is performed and DataOut returns the old value.
- Read|Write going high in the same cycle Ready falls is treated as a new request from IDLE. Ready goes high again one cycle later.
- Blink timing:
  - A prescaler counts 0..BLINK_DIV-1 and wraps.
  - On wrap, the blink phase toggles.
  - During the OFF phase (1), LEDs whose blink_mask bit is 1 are forced off.
- PWM timing:
  - A step prescaler counts 0..PWM_DIV-1.
  - On each wrap, a 4-bit step counter increments, wrapping 15->0.
  - pwm_on = (step <= brightness).
  - brightness=15 gives always on; brightness=0 gives 1/16 duty.
- Output: LED_out[i] <= pattern[i] & pwm_on & ~(blink_mask[i] & phase), registered. A change to pattern or control reaches LED_out 1 cycle after the capture edge.
- Counter behaviour:
  - Counters free-run and are unaffected by bus writes.
  - Prescaler widths are sized to their parameters with no overflow beyond the stated wrap points.
- Reset mid-transaction: Ready drops at once and the FSM returns to IDLE. Registers return to their reset values, so a write in progress is lost. The master must restart the handshake.

Optional Feature:
- Macro: LED_DRIVER_PWM_EN.
- When defined: brightness register and PWM logic as described above.
- When undefined:
  - No PWM counters are built and pwm_on is constant 1.
  - Writes to brightness are ignored.
  - Control reads return brightness field = 4'hF.
  - Blink and handshake behaviour are unchanged.

Test Plan:
- Reset, write, read back: release reset; Write=1, Address=0, DataIn=16'h00A5, hold 3 cycles, then drop. Ready must rise 1 cycle after Write and fall 1 cycle after the drop. LED_out=8'hA5 from the cycle after capture. A following Read at Address 0 returns DataOut=16'h00A5.
- Simultaneous Read and Write: pattern=8'h0F; assert Read=Write=1, Address=0, DataIn=16'h00F0. DataOut must be 16'h000F and LED_out must become 8'hF0.
- Blink (BLINK_DIV=4): pattern=8'hFF, control write 16'h00FF (mask 8'h0F, brightness 15). LED_out must alternate 8'hFF / 8'hF0 every 4 cycles.
- PWM (PWM_DIV=1, macro defined): pattern=8'h01, brightness=3. LED_out[0] must be high for 4 of every 16 cycles. With brightness=0 it is high 1 of 16. With the macro undefined, a control read shows brightness 4'hF and LED_out[0] is always high.
- Held request, no re-write: hold Write at Address 0 for 10 cycles while DataIn changes from 16'h0011 to 16'h0022 mid-hold. Pattern must stay 8'h11.
- Reset mid-handshake: assert reset while Ready=1. Ready, LED_out and DataOut must go to 0 immediately. After release, a control read returns 16'h000F.

Source files
------------

// File: rtl/led_driver.sv
// led_driver: bus-mapped 8-LED output port with per-LED blink and global PWM brightness.
//
// A 4-way handshake bus writes/reads two registers:
//   Address 0 : LED pattern        {8'h00, pattern}
//   Address 1 : control            {4'h0, blink_mask, brightness}
// LED_out is a registered drive: pattern gated by the PWM duty and the blink phase.
//
// Optional build macro LED_DRIVER_PWM_EN: when defined, the brightness register and
// PWM step counters are built. When undefined, the LEDs are always at full duty,
// brightness writes are dropped and control reads report brightness 4'hF.
//
// Ports:
//   clock    in   1   system clock, rising edge
//   reset    in   1   asynchronous active-low reset
//   Read     in   1   bus read request
//   Write    in   1   bus write request
//   Address  in   1   register select (0 pattern, 1 control)
//   DataIn   in  16   write data
//   Ready    out  1   handshake acknowledge
//   DataOut  out 16   read data, valid while Ready=1
//   LED_out  out  8   active-high LED drive
module led_driver #(
  parameter int unsigned BLINK_DIV = 25000000,
  parameter int unsigned PWM_DIV   = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Read,
  input  logic        Write,
  input  logic        Address,
  input  logic [15:0] DataIn,
  output logic        Ready,
  output logic [15:0] DataOut,
  output logic [7:0]  LED_out
);

  localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        req_c;
  logic        capture_c;
  logic [15:0] rd_data_c;

  logic [7:0]  pattern;
  logic [7:0]  blink_mask;
  logic [3:0]  brightness;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               pwm_on_c;

  assign req_c = Read | Write;

  // Next-state logic for the handshake; capture happens only on IDLE->ACK.
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          state_d   = ST_ACK;
          capture_c = 1'b1;
        end
      end
      ST_ACK: begin
        if (!req_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; Ready tracks the state it is entering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      Ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      Ready   <= (state_d == ST_ACK);
    end
  end

  // Read mux sees pre-write contents, so a combined read/write returns the old value.
  assign rd_data_c = Address ? {4'h0, blink_mask, brightness} : {8'h00, pattern};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      DataOut <= 16'h0000;
    end else if (capture_c) begin
      DataOut <= rd_data_c;
    end
  end

  // Pattern and blink mask registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pattern    <= 8'h00;
      blink_mask <= 8'h00;
    end else if (capture_c && Write) begin
      if (Address) begin
        blink_mask <= DataIn[11:4];
      end else begin
        pattern <= DataIn[7:0];
      end
    end
  end

  // Blink half-period prescaler and phase (0 = ON).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

`ifdef LED_DRIVER_PWM_EN
  localparam int unsigned PWM_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [PWM_W-1:0] pwm_pre;
  logic [3:0]       pwm_step;
  logic             unused_ok;

  assign unused_ok = &{1'b0, DataIn[15:12]};

  // Brightness register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      brightness <= 4'hF;
    end else if (capture_c && Write && Address) begin
      brightness <= DataIn[3:0];
    end
  end

  // PWM step prescaler and 16-step frame counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_pre  <= '0;
      pwm_step <= 4'h0;
    end else if (pwm_pre == PWM_W'(PWM_DIV - 1)) begin
      pwm_pre  <= '0;
      pwm_step <= pwm_step + 4'h1;
    end else begin
      pwm_pre <= pwm_pre + PWM_W'(1);
    end
  end

  assign pwm_on_c = (pwm_step <= brightness);
`else
  logic unused_ok;

  // No dimming hardware: full duty, brightness pinned at maximum.
  assign brightness = 4'hF;
  assign pwm_on_c   = 1'b1;
  assign unused_ok  = &{1'b0, DataIn[15:12], DataIn[3:0], PWM_DIV[0]};
`endif

  // Registered LED drive: blinking LEDs are forced off during the OFF phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      LED_out <= 8'h00;
    end else begin
      LED_out <= pattern & {8{pwm_on_c}} & ~(blink_mask & {8{blink_phase}});
    end
  end

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: scoreboard for bus reads, per-cycle LED model.
module tb_led_driver;

  localparam int unsigned BLINK_DIV = 4;
  localparam int unsigned PWM_DIV   = 1;
`ifdef LED_DRIVER_PWM_EN
  localparam bit PWM_EN = 1'b1;
`else
  localparam bit PWM_EN = 1'b0;
`endif

  logic        clock   = 1'b0;
  logic        reset   = 1'b0;
  logic        Read    = 1'b0;
  logic        Write   = 1'b0;
  logic        Address = 1'b0;
  logic [15:0] DataIn  = 16'h0000;
  logic        Ready;
  logic [15:0] DataOut;
  logic [7:0]  LED_out;

  led_driver #(.BLINK_DIV(BLINK_DIV), .PWM_DIV(PWM_DIV)) dut (
    .clock   (clock),
    .reset   (reset),
    .Read    (Read),
    .Write   (Write),
    .Address (Address),
    .DataIn  (DataIn),
    .Ready   (Ready),
    .DataOut (DataOut),
    .LED_out (LED_out)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural register model.
  logic [7:0] m_pattern = 8'h00;
  logic [7:0] m_mask    = 8'h00;
  logic [3:0] m_bright  = 4'hF;

  typedef struct {
    bit          is_read;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // Rising edges seen since reset was released.
  int unsigned edge_cnt;
  always @(posedge clock or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // LED value produced by the edge that follows n completed edges since reset.
  function automatic logic [7:0] model_led(input int unsigned n);
    bit          phase;
    int unsigned step;
    bit          pwm;
    phase = ((n / BLINK_DIV) % 2) == 1;
    step  = (n / PWM_DIV) % 16;
    pwm   = PWM_EN ? (step <= m_bright) : 1'b1;
    return m_pattern & {8{pwm}} & ~(m_mask & {8{phase}});
  endfunction

  function automatic logic [15:0] model_read(input bit addr);
    logic [3:0] b;
    b = PWM_EN ? m_bright : 4'hF;
    return addr ? {4'h0, m_mask, b} : {8'h00, m_pattern};
  endfunction

  task automatic model_write(input bit addr, input logic [15:0] d);
    if (addr) begin
      m_mask = d[11:4];
      if (PWM_EN) m_bright = d[3:0];
    end else begin
      m_pattern = d[7:0];
    end
  endtask

  task automatic model_reset();
    m_pattern = 8'h00;
    m_mask    = 8'h00;
    m_bright  = 4'hF;
  endtask

  // Per-cycle LED checker; also checks that reset holds all outputs low.
  logic [7:0] led_pend;
  bit         pend_ok = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      check("reset_led", 32'(LED_out), 32'h0);
      check("reset_ready", 32'(Ready), 32'h0);
      check("reset_dataout", 32'(DataOut), 32'h0);
      pend_ok = 1'b0;
    end else begin
      if (pend_ok) check("led_model", 32'(LED_out), 32'(led_pend));
      led_pend = model_led(edge_cnt);
      pend_ok  = 1'b1;
    end
  end

  // Monitor: each new acknowledge retires one scoreboard entry.
  bit ready_prev = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      ready_prev = 1'b0;
    end else begin
      if (Ready && !ready_prev) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_ack", 32'(sb_q.size()), 32'h1);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          if (e.is_read) check("read_data", 32'(DataOut), 32'(e.exp));
        end
      end
      ready_prev = Ready;
    end
  end

  // One bus transaction; b2b skips the idle cycle before asserting the request.
  task automatic txn(input bit rd, input bit wr, input bit addr, input logic [15:0] d,
                     input int hold, input bit b2b);
    sb_t e;
    if (!b2b) @(negedge clock);
    Read = rd; Write = wr; Address = addr; DataIn = d;
    e.is_read = rd;
    e.exp     = model_read(addr);
    sb_q.push_back(e);
    @(posedge clock); #1;
    if (wr) model_write(addr, d);
    @(negedge clock);
    check("ready_rise", 32'(Ready), 32'h1);
    repeat (hold) @(negedge clock);
    Read = 1'b0; Write = 1'b0; DataIn = 16'($urandom);
    @(negedge clock);
    check("ready_fall", 32'(Ready), 32'h0);
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    sb_t e;

    repeat (3) @(negedge clock);
    #2 reset = 1'b1;

    // Write, then read back the pattern.
    txn(1'b0, 1'b1, 1'b0, 16'h00A5, 3, 1'b0);
    check("led_a5", 32'(LED_out), 32'hA5);
    txn(1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
    check("readback_a5", 32'(DataOut), 32'h00A5);

    // Simultaneous read and write returns the old value.
    txn(1'b0, 1'b1, 1'b0, 16'h000F, 0, 1'b0);
    txn(1'b1, 1'b1, 1'b0, 16'h00F0, 0, 1'b1);
    check("rw_old_value", 32'(DataOut), 32'h000F);
    check("rw_led_f0", 32'(LED_out), 32'hF0);

    // Held write with changing data does not re-write.
    @(negedge clock);
    Write = 1'b1; Address = 1'b0; DataIn = 16'h0011;
    e.is_read = 1'b0; e.exp = 16'h0; sb_q.push_back(e);
    @(posedge clock); #1;
    model_write(1'b0, 16'h0011);
    repeat (5) @(negedge clock);
    DataIn = 16'h0022;
    repeat (5) @(negedge clock);
    Write = 1'b0;
    @(negedge clock);
    check("held_ready_fall", 32'(Ready), 32'h0);
    txn(1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
    check("held_pattern", 32'(DataOut), 32'h0011);

    // Blink: lower nibble alternates every BLINK_DIV cycles.
    txn(1'b0, 1'b1, 1'b0, 16'h00FF, 0, 1'b0);
    txn(1'b0, 1'b1, 1'b1, 16'h00FF, 0, 1'b0);
    cnt_a = 0; cnt_b = 0;
    repeat (2 * BLINK_DIV) begin
      @(negedge clock);
      if (LED_out == 8'hFF) cnt_a++;
      if (LED_out == 8'hF0) cnt_b++;
    end
    check("blink_on_cycles", 32'(cnt_a), 32'(BLINK_DIV));
    check("blink_off_cycles", 32'(cnt_b), 32'(BLINK_DIV));

    // PWM duty over one frame.
    txn(1'b0, 1'b1, 1'b0, 16'h0001, 0, 1'b0);
    txn(1'b0, 1'b1, 1'b1, 16'h0003, 0, 1'b0);
    cnt_a = 0;
    repeat (16 * PWM_DIV) begin
      @(negedge clock);
      if (LED_out[0]) cnt_a++;
    end
    check("pwm_duty_b3", 32'(cnt_a), PWM_EN ? 32'd4 : 32'd16);
    txn(1'b0, 1'b1, 1'b1, 16'h0000, 0, 1'b0);
    cnt_a = 0;
    repeat (16 * PWM_DIV) begin
      @(negedge clock);
      if (LED_out[0]) cnt_a++;
    end
    check("pwm_duty_b0", 32'(cnt_a), PWM_EN ? 32'd1 : 32'd16);
    txn(1'b1, 1'b0, 1'b1, 16'h0000, 0, 1'b0);
    check("ctrl_read_bright", 32'(DataOut), PWM_EN ? 32'h0000 : 32'h000F);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      bit rd;
      bit wr;
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      txn(rd, wr, 1'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end

    // Reset in the middle of an acknowledged read.
    @(negedge clock);
    Read = 1'b1; Address = 1'b1;
    e.is_read = 1'b1; e.exp = model_read(1'b1); sb_q.push_back(e);
    @(negedge clock);
    check("mid_ready_high", 32'(Ready), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_ready", 32'(Ready), 32'h0);
    check("mid_reset_led", 32'(LED_out), 32'h0);
    check("mid_reset_dataout", 32'(DataOut), 32'h0);
    model_reset();
    Read = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    txn(1'b1, 1'b0, 1'b1, 16'h0000, 1, 1'b0);
    check("post_reset_ctrl", 32'(DataOut), 32'h000F);

    repeat (5) @(negedge clock);
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
